clock_time_keeper: RTL
======================

# clock_time_keeper

Parametrised time-of-day keeper: divides the system clock down to a 1 s tick and maintains seconds/minutes/hours with correct cascaded rollover. Adds a field-select set mode driven by ORDER/INCREMENT, 12/24-hour display and tick/day-wrap strobes. Feeds the display/formatting logic. The clock frequency is a parameter, so simulation can run with a tiny divider.

## Interface
- CLOCK_FREQ, 50000000, input clock cycles per second; legal values are ≥ 2.
- CNT_W, $clog2(CLOCK_FREQ), width of the prescale counter.
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-low reset.
- INCREMENT  input  1  synchronous set-mode increment request; rising-edge detected internally.
- ORDER  input  2  field select:
  - 0: run.
  - 1: set seconds.
  - 2: set minutes.
  - 3: set hours.
- MODE_12H  input  1  0 = 24-hour display; 1 = 12-hour display.
- seconds  output  8  current seconds, 0..59.
- minutes  output  8  current minutes, 0..59.
- hours  output  8  displayed hours: 0..23 in 24-hour mode, 1..12 in 12-hour mode.
- pm  output  1  1 when internal hours ≥ 12, regardless of MODE_12H.
- tick  output  1  one-cycle pulse on each run-mode seconds advance.
- day_wrap  output  1  one-cycle pulse on the 23:59:59 → 00:00:00 advance.

## Operation
- Internal state:
  - Prescale counter cnt.
  - sec_r, min_r, hr_r (0..23, binary).
  - inc_d, the previous INCREMENT sample.
- Reset values: cnt=0, sec_r=min_r=hr_r=0, inc_d=0, tick=0, day_wrap=0.
- Run mode (ORDER=0):
  - cnt increments every cycle.
  - When cnt == CLOCK_FREQ-1: cnt←0 and sec_r advances.
  - Carry rules:
    - sec_r 59→0 carries into min_r.
    - min_r advances only on a seconds carry; 59→0 carries into hr_r.
    - hr_r advances only on a minutes carry; 23→0 asserts day_wrap.
  - Exactly one second elapses per CLOCK_FREQ cycles.
  - INCREMENT is ignored.
- Set mode (ORDER≠0):
  - cnt is forced to 0 and held; tick and day_wrap stay 0.
  - Increment event = INCREMENT=1 and inc_d=0. It increments only the selected field, modulo its range (59→0, 23→0), with no carry into other fields.
  - INCREMENT held high produces exactly one increment.
- inc_d samples INCREMENT every cycle in all modes.
- Display:
  - hours = hr_r when MODE_12H=0.
  - When MODE_12H=1: hr_r 0 → 12, 1..12 → unchanged, 13..23 → hr_r-12.
  - pm = (hr_r ≥ 12).
  - hours and pm are combinational from hr_r and MODE_12H.
  - seconds and minutes are direct register outputs.

## Timing
- tick and day_wrap are registered. They are high in the same cycle that the new sec_r (and min_r, hr_r) values first appear.
- Latencies:
  - First tick after reset or after leaving set mode: CLOCK_FREQ cycles after cnt starts from 0.
  - Set-mode increment: the field updates on the first rising edge that samples INCREMENT=1 with inc_d=0.
- ORDER changes mid-second: cnt clears on the first edge with ORDER≠0. The partial second is discarded.
- ORDER changing from set to run in the same cycle as an INCREMENT edge: the increment is dropped (the run-mode rule applies).
- MODE_12H toggles: hours and pm update combinationally; internal state is unaffected.
- Asynchronous reset mid-second or mid-set: all state clears immediately. Outputs read seconds=0, minutes=0, hours=0 (12 if MODE_12H=1) and pm=0 while RST is low.

## Configuration
- Macro: CLOCK_TIME_ALARM_EN.
- Defined:
  - Adds input ALARM_ENABLE (1 bit), input ALARM_HOURS (8 bits, 24-hour), input ALARM_MINUTES (8 bits), and output alarm (1 bit).
  - alarm is registered and resets to 0.
  - alarm sets on the run-mode advance that lands on hr_r==ALARM_HOURS, min_r==ALARM_MINUTES, sec_r==0 while ALARM_ENABLE=1. It becomes high in the same cycle as that advance.
  - alarm stays high until ALARM_ENABLE=0 or reset.
  - Set-mode edits never trigger alarm.
- Not defined: the alarm ports and logic are absent. Behaviour is otherwise identical.

## Test plan
All scenarios use CLOCK_FREQ=4.
- Reset: drive RST=0 mid-count at 05:06:07 → outputs become 00:00:00 and tick=0 immediately; after RST=1, the first tick arrives 4 cycles later with seconds=1.
- Cascade: run 240 cycles from reset → minutes=1, seconds=0, hours=0; exactly 60 tick pulses; day_wrap never high.
- Day wrap:
  - Set to 23:59:59 using ORDER=3/2/1 with 23/59/59 INCREMENT pulses, then ORDER=0.
  - After 4 cycles → 00:00:00, with tick=1 and day_wrap=1 for exactly one cycle.
- Set-mode wrap:
  - ORDER=2 from 00:00:00, apply 61 pulses → minutes=1, hours=0, seconds=0, no tick.
  - INCREMENT held high for 10 cycles → one increment only.
- 12-hour display:
  - hr_r=13, MODE_12H=1 → hours=1, pm=1; hr_r=0 → hours=12, pm=0.
  - With MODE_12H=0, hr_r=13 → hours=13.
- Alarm (CLOCK_TIME_ALARM_EN, ALARM_ENABLE=1, alarm 00:01):
  - Run from reset → alarm rises at cycle 240 together with minutes=1.
  - Alarm stays high until ALARM_ENABLE=0, then clears on the next edge.

Source files
------------

// File: rtl/clock_time_keeper_if.sv
// clock_time_keeper_if: control/display bundle for clock_time_keeper.
// master drives INCREMENT/ORDER/MODE_12H (and alarm settings when
// CLOCK_TIME_ALARM_EN is defined) and reads the time outputs; slave is the keeper.
interface clock_time_keeper_if;
  logic       INCREMENT;
  logic [1:0] ORDER;
  logic       MODE_12H;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       pm;
  logic       tick;
  logic       day_wrap;
`ifdef CLOCK_TIME_ALARM_EN
  logic       ALARM_ENABLE;
  logic [7:0] ALARM_HOURS;
  logic [7:0] ALARM_MINUTES;
  logic       alarm;
  modport master (output INCREMENT, ORDER, MODE_12H, ALARM_ENABLE, ALARM_HOURS, ALARM_MINUTES,
                  input seconds, minutes, hours, pm, tick, day_wrap, alarm);
  modport slave (input INCREMENT, ORDER, MODE_12H, ALARM_ENABLE, ALARM_HOURS, ALARM_MINUTES,
                 output seconds, minutes, hours, pm, tick, day_wrap, alarm);
`else
  modport master (output INCREMENT, ORDER, MODE_12H,
                  input seconds, minutes, hours, pm, tick, day_wrap);
  modport slave (input INCREMENT, ORDER, MODE_12H,
                 output seconds, minutes, hours, pm, tick, day_wrap);
`endif
endinterface

// File: rtl/clock_time_keeper.sv
// clock_time_keeper: time-of-day keeper with 1 s prescaler, set mode and 12/24h display.
// Ports: CLK (clock), RST (async active-low reset), bus (slave modport):
//   INCREMENT/ORDER set-mode controls, MODE_12H display select,
//   seconds/minutes/hours/pm display, tick/day_wrap strobes.
// Optional alarm (ALARM_ENABLE/ALARM_HOURS/ALARM_MINUTES -> alarm) with CLOCK_TIME_ALARM_EN.
module clock_time_keeper #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int CNT_W      = $clog2(CLOCK_FREQ)
) (
  input logic CLK,
  input logic RST,
  clock_time_keeper_if.slave bus
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic inc_q, inc_d, tick_q, tick_d, day_wrap_q, day_wrap_d;
  logic run, adv, inc_ev, sec_c, min_c;
`ifdef CLOCK_TIME_ALARM_EN
  logic alarm_q, alarm_d;
`endif
  always_comb begin
    run = bus.ORDER == 2'd0;
    inc_ev = bus.INCREMENT & ~inc_q;
    adv = run && cnt_q == CNT_W'(CLOCK_FREQ - 1);
    sec_c = adv && sec_q == 8'd59;
    min_c = sec_c && min_q == 8'd59;
    // leaving run mode discards the partial second
    cnt_d = (!run || adv) ? '0 : cnt_q + 1'b1;
    // set-mode edits wrap within their own field and never carry
    sec_d = (adv || (bus.ORDER == 2'd1 && inc_ev)) ? (sec_q == 8'd59 ? 8'd0 : sec_q + 8'd1) : sec_q;
    min_d = (sec_c || (bus.ORDER == 2'd2 && inc_ev)) ? (min_q == 8'd59 ? 8'd0 : min_q + 8'd1) : min_q;
    hr_d = (min_c || (bus.ORDER == 2'd3 && inc_ev)) ? (hr_q == 8'd23 ? 8'd0 : hr_q + 8'd1) : hr_q;
    tick_d = adv;
    day_wrap_d = min_c && hr_q == 8'd23;
    inc_d = bus.INCREMENT;
`ifdef CLOCK_TIME_ALARM_EN
    // latches on the advance that lands on HH:MM:00, held until disabled
    alarm_d = bus.ALARM_ENABLE && (alarm_q ||
              (adv && hr_d == bus.ALARM_HOURS && min_d == bus.ALARM_MINUTES && sec_d == 8'd0));
`endif
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      sec_q <= '0;
      min_q <= '0;
      hr_q <= '0;
      inc_q <= 1'b0;
      tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
`ifdef CLOCK_TIME_ALARM_EN
      alarm_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q <= hr_d;
      inc_q <= inc_d;
      tick_q <= tick_d;
      day_wrap_q <= day_wrap_d;
`ifdef CLOCK_TIME_ALARM_EN
      alarm_q <= alarm_d;
`endif
    end
  end
  assign bus.seconds = sec_q;
  assign bus.minutes = min_q;
  assign bus.hours = !bus.MODE_12H ? hr_q : hr_q == 8'd0 ? 8'd12 : hr_q > 8'd12 ? hr_q - 8'd12 : hr_q;
  assign bus.pm = hr_q >= 8'd12;
  assign bus.tick = tick_q;
  assign bus.day_wrap = day_wrap_q;
`ifdef CLOCK_TIME_ALARM_EN
  assign bus.alarm = alarm_q;
`endif
endmodule
